// File: rtl/alu_multdiv.sv
// alu_multdiv: sequential signed multiply/divide unit.
// Multiply uses unsigned shift-add over the operand magnitudes.
// Divide uses unsigned restoring division over the operand magnitudes.
// The sign is applied when the result is registered, at DONE entry.
// Latency is fixed at WIDTH+1 edges from the start pulse to DONE entry.
module alu_multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;          // |A| (multiplicand)
  logic [WIDTH-1:0]   b_q, b_d;          // |B| (divisor)
  logic               sign_q, sign_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;      // MIN_NEG / -1 divide
  logic [2*WIDTH-1:0] work_q, work_d;    // product, or {remainder, quotient}
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;

  logic               start_s;
  logic               last_s;
  logic               done_entry_s;
  logic [WIDTH:0]     mul_sum_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               mul_exc_s;
  logic [WIDTH-1:0]   quot_s;

  // Two's complement magnitude; MIN_NEG maps to itself as an unsigned value.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return (~v) + ONE_W;
    end else begin
      return v;
    end
  endfunction

  assign start_s      = ctrl_MULT | ctrl_DIV;
  assign last_s       = (cnt_q == CNT_LAST);
  assign done_entry_s = !start_s && ((state_q == S_MUL) || (state_q == S_DIV)) && last_s;

  // Arithmetic for one iteration and for the final signed result.
  always_comb begin
    mul_sum_s  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    div_ge_s   = (work_q[2*WIDTH-1:WIDTH-1] >= {1'b0, b_q});
    div_diff_s = work_q[2*WIDTH-2:WIDTH-1] - b_q;
    prod_s     = sign_q ? ((~work_q) + ONE_2W) : work_q;
    mul_exc_s  = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
    quot_s     = sign_q ? ((~work_q[WIDTH-1:0]) + ONE_W) : work_q[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a start pulse overrides every state, MUL wins ties.
  always_comb begin
    state_d = state_q;
    if (ctrl_MULT) begin
      state_d = S_MUL;
    end else if (ctrl_DIV) begin
      state_d = S_DIV;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_MUL:   state_d = last_s ? S_DONE : S_MUL;
        S_DIV:   state_d = last_s ? S_DONE : S_DIV;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values.
  always_comb begin
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    work_d   = work_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    if (start_s) begin
      a_d    = abs_val(data_operandA);
      b_d    = abs_val(data_operandB);
      sign_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dbz_d  = (data_operandB == {WIDTH{1'b0}});
      ovf_d  = (data_operandA == MIN_NEG) && (data_operandB == {WIDTH{1'b1}});
      cnt_d  = {CW{1'b0}};
      work_d = {{WIDTH{1'b0}}, (ctrl_MULT ? abs_val(data_operandB) : abs_val(data_operandA))};
    end else if (done_entry_s) begin
      rdy_d = 1'b1;
      if (state_q == S_MUL) begin
        result_d = prod_s[WIDTH-1:0];
        exc_d    = mul_exc_s;
      end else if (dbz_q) begin
        result_d = {WIDTH{1'b0}};
        exc_d    = 1'b1;
      end else begin
        result_d = quot_s;
        exc_d    = ovf_q;
      end
    end else if (state_q == S_MUL) begin
      cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      work_d = {mul_sum_s, work_q[WIDTH-1:1]};
    end else if (state_q == S_DIV) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      if (div_ge_s) begin
        work_d = {div_diff_s, work_q[WIDTH-2:0], 1'b1};
      end else begin
        work_d = {work_q[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= {CW{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      sign_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      work_q   <= {(2*WIDTH){1'b0}};
      result_q <= {WIDTH{1'b0}};
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      work_q   <= work_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: doc/alu_multdiv.md
# alu_multdiv

Sequential signed 32-bit multiply/divide unit in the ALU. It executes MIPS `mult`/`div`-class operations over multiple cycles. Its registered result and exception flag feed the ALU result-select mux, which switches between the single-cycle ALU output and this unit's output. Operands come from the execute-stage operand registers. The pipeline stalls on the busy state and resumes on `data_resultRDY`.

## Interface
- `WIDTH`, 32, operand/result width in bits; iteration count equals `WIDTH`.
- `clock`  input  1  sole clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `data_operandA`  input  WIDTH  multiplicand / dividend, two's complement.
- `data_operandB`  input  WIDTH  multiplier / divisor, two's complement.
- `ctrl_MULT`  input  1  single-cycle start pulse for multiply.
- `ctrl_DIV`  input  1  single-cycle start pulse for divide.
- `data_result`  output  WIDTH  registered result; holds until the next completion.
- `data_exception`  output  1  registered overflow / divide-by-zero flag; same update rule as `data_result`.
- `data_resultRDY`  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, MUL, DIV, DONE. Iteration counter is 6 bits wide (log2(WIDTH)+1).
- **Start:** at any edge with `ctrl_MULT`=1 or `ctrl_DIV`=1 (any state, including busy):
  - Latch |A|, |B|, sign(A)^sign(B), the divide-by-zero flag (B==0) and the special-overflow flags.
  - Clear the accumulator and counter, then enter MUL or DIV.
  - If both pulses are high in the same cycle, MUL wins.
  - A start while busy aborts the in-flight operation. The aborted operation never produces `data_resultRDY`.
- **MUL:** unsigned shift-add over the magnitudes, one multiplier bit per edge, into a 2*WIDTH-bit product P.
- **DIV:** unsigned restoring division over the magnitudes, one quotient bit per edge.
- **Counter:** increments each iteration. After the WIDTH-th iteration the next edge enters DONE.
- **DONE entry edge:** register the result, the exception flag and `data_resultRDY`=1.
- **Multiply result:** S = sign ? -P : P (2*WIDTH-bit two's complement). `data_result` = S[WIDTH-1:0]. `data_exception` = 1 iff S[2*WIDTH-1:WIDTH-1] is not all-equal.
  - Example: 0x80000000*1 gives no exception; 0x80000000*0xFFFFFFFF gives an exception.
- **Divide result:**
  - Quotient truncates toward zero and is negated if sign=1. The remainder is discarded.
  - B==0: `data_result`=0, `data_exception`=1.
  - A=0x80000000, B=0xFFFFFFFF: `data_result`=0x80000000, `data_exception`=1.
- **DONE to IDLE:** on the next edge DONE returns to IDLE and `data_resultRDY` returns to 0. A start pulse seen in DONE goes straight to MUL/DIV, and `data_resultRDY` still drops.
- **Reset (`reset_n` low):** immediate, asynchronous.
  - State=IDLE, counter=0, internal registers=0.
  - `data_result`=0, `data_exception`=0, `data_resultRDY`=0.
  - Reset mid-operation discards the operation with no RDY pulse. Operation resumes on the first edge after deassertion.
- Start pulses while `reset_n` is low are ignored.

## Timing
- Start pulse sampled at edge k. Iterations occur at edges k+1 through k+WIDTH. DONE is entered at edge k+WIDTH+1.
- `data_resultRDY` is high for exactly the cycle between edges k+WIDTH+1 and k+WIDTH+2, i.e. 33 cycles after the start cycle for WIDTH=32.
- Latency is fixed and identical for multiply, divide, divide-by-zero and overflow cases. There is no early termination.
- `data_result` and `data_exception` change only at DONE entry or on reset. They are stable while busy, so the downstream mux may sample them whenever `data_resultRDY`=1 or later.
- Operands only need to be valid in the start cycle. Operand changes while busy have no effect.
- Idle with no start: outputs hold and RDY stays 0.

## Test plan
- **Multiply basic:** reset, release, MULT pulse with A=7, B=0xFFFFFFFD → exactly one RDY pulse 33 cycles later, result 0xFFFFFFEB, exception 0. Result holds for 10 further idle cycles.
- **Multiply overflow:** A=0x00010000, B=0x00010000 → result 0x00000000, exception 1. A=0x80000000, B=1 → result 0x80000000, exception 0.
- **Divide:**
  - A=0xFFFFFFF9 (-7), B=2 → result 0xFFFFFFFD, exception 0.
  - A=100, B=0xFFFFFFF6 → result 0xFFFFFFF6.
  - A=5, B=0 → result 0, exception 1, RDY still at 33 cycles.
  - A=0x80000000, B=0xFFFFFFFF → result 0x80000000, exception 1.
- **Restart while busy:** DIV pulse (A=50, B=5), then a MULT pulse 10 cycles later (A=3, B=4) → exactly one RDY pulse, 33 cycles after the MULT pulse, result 12. Both ctrl pulses in the same cycle (A=6, B=3) → result 18.
- **Reset mid-operation:** MULT pulse, `reset_n` low asynchronously 15 cycles later (mid-cycle) → outputs 0 immediately. After release, no RDY ever appears; a new DIV 9/3 completes with result 3.
- **Back-to-back:** MULT issued in the RDY cycle of a previous DIV → RDY drops next cycle, new RDY exactly 33 cycles after the second pulse, and the previous result is held until then.
